// File: rtl/sel_accumulator_if.sv
// Handshake bundle between the SEL sequencer side and sel_accumulator.
// Ports: sel/seed control, sample valid/ready/data, result valid/ready/data,
// saturation flag and completed-block counter.
interface sel_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 sel;
    logic [WIDTH-1:0]     seed;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 ovf;
    logic [7:0]           blk_cnt;

    // Sequencer / sample source / result sink side.
    modport master (
        output sel,
        output seed,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  ovf,
        input  blk_cnt
    );

    // Accumulator side.
    modport slave (
        input  sel,
        input  seed,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output ovf,
        output blk_cnt
    );
endinterface

// File: rtl/sel_accumulator.sv
// Seeded saturating block accumulator gated by the sequencer SEL signal.
// Ports: i_clk, i_rst_n (async, active low), io_bus (sel_accumulator_if.slave):
//   sel/seed in, in_valid/in_ready/in_data sample port,
//   out_valid/out_ready/out_data result port, ovf flag, blk_cnt counter.
module sel_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT_N   = 4
) (
    input logic              i_clk,
    input logic              i_rst_n,
    sel_accumulator_if.slave io_bus
);

    localparam int CNT_W = (COUNT_N > 1) ? $clog2(COUNT_N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_N - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_seed_q;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_data;
    logic                 r_ovf;
    logic [7:0]           r_blk_cnt;

    logic                 w_in_ready;
    logic                 w_take;
    logic                 w_last;
    logic                 w_give;
    logic                 w_load;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_sat;
    logic [ACC_WIDTH-1:0] w_seed_ext;
    logic [ACC_WIDTH-1:0] w_seedq_ext;

    assign w_seed_ext  = ACC_WIDTH'(io_bus.seed);
    assign w_seedq_ext = ACC_WIDTH'(r_seed_q);

    // One extra bit catches the carry that signals saturation.
    assign w_sum = {1'b0, r_acc}
                 + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, io_bus.in_data};
    assign w_sat = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                    : w_sum[ACC_WIDTH-1:0];

    // Handshake strobes; SEL low gates the sample port immediately.
    assign w_in_ready = (r_state == S_ACCUM) & io_bus.sel;
    assign w_take     = io_bus.in_valid & w_in_ready;
    assign w_last     = w_take & (r_cnt == LAST);
    assign w_give     = r_out_valid & io_bus.out_ready;
    // Abort (SEL low anywhere) takes the LOAD path and wins over a result handshake.
    assign w_load     = (r_state == S_LOAD) | ~io_bus.sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!io_bus.sel) begin
            w_state_nxt = S_LOAD;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    w_state_nxt = S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_give) begin
                        w_state_nxt = S_ACCUM;
                    end
                end
                default: begin
                    w_state_nxt = S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seed_q    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
            r_blk_cnt   <= '0;
        end else if (w_load) begin
            // Seed tracks SEED every LOAD cycle, including the SEL-rise edge.
            r_seed_q    <= io_bus.seed;
            r_acc       <= w_seed_ext;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_blk_cnt   <= '0;
        end else if (r_state == S_ACCUM) begin
            if (w_take) begin
                r_acc <= w_sat;
                if (w_sum[ACC_WIDTH]) begin
                    r_ovf <= 1'b1;
                end
                if (w_last) begin
                    r_cnt       <= '0;
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else if (r_state == S_DONE) begin
            if (w_give) begin
                r_out_valid <= 1'b0;
                r_acc       <= w_seedq_ext;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
                r_blk_cnt   <= r_blk_cnt + 8'd1;
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.ovf       = r_ovf;
    assign io_bus.blk_cnt   = r_blk_cnt;

endmodule
